// File: rtl/sc_lane_sched_pkg.sv
// Shared definitions for the lane load scheduler: FSM state encodings
// and the round-robin pointer width helper.
package sc_lane_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        LOAD  = 2'b10,
        ACK   = 2'b11
    } sc_sched_state_t;

    // Pointer width for a given lane count; never narrower than one bit.
    function automatic int sc_ptr_width(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

    localparam int SC_LANE_SCHED_NUM_LANES = 4;
    localparam int SC_LANE_SCHED_PTR_W     = sc_ptr_width(SC_LANE_SCHED_NUM_LANES);

endpackage

// File: rtl/sc_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting lane after
// the pointer (pointer+1, pointer+2, ... modulo the lane count).
module sc_rr_arbiter
    import sc_lane_sched_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int PTR_W     = sc_ptr_width(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [PTR_W-1:0]     pointer,
    input  logic                 enable,
    output logic                 valid,
    output logic [PTR_W-1:0]     sel_idx,
    output logic [NUM_LANES-1:0] sel_onehot
);

    logic [PTR_W-1:0] cand_idx;

    // Scan lanes starting just after the last served one; first hit wins.
    always_comb begin
        valid      = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        cand_idx   = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            cand_idx = PTR_W'((int'(pointer) + i) % NUM_LANES);
            if (enable && !valid && req[cand_idx]) begin
                valid                = 1'b1;
                sel_idx              = cand_idx;
                sel_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_lane_load_scheduler.sv
// Shares one parallel-load path among the lane level FSMs. A lane is granted
// round-robin, its pattern is captured once, the load strobe is held for
// LOAD_CYCLES clocks and a one-cycle LOADED pulse is returned to that lane.
module sc_lane_load_scheduler
    import sc_lane_sched_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,
    parameter int NUM_LANES     = 4,
    parameter int LOAD_CYCLES   = 8
) (
    input  logic                               SC_STATEMACHINE_NVE_CLOCK_50,
    input  logic                               SC_STATEMACHINE_NVE_RESET,
    input  logic                               SC_LANE_SCHED_ENABLE_IN,
    input  logic [NUM_LANES-1:0]               SC_LANE_SCHED_REQ_IN,
    input  logic [NUM_LANES*DATAWIDTH_BUS-1:0] SC_LANE_SCHED_PATTERN_IN,
    output logic [NUM_LANES-1:0]               SC_LANE_SCHED_GRANT_OUT,
    output logic [DATAWIDTH_BUS-1:0]           SC_LANE_SCHED_DATA_OUT,
    output logic                               SC_LANE_SCHED_LOAD_OUT,
    output logic [NUM_LANES-1:0]               SC_LANE_SCHED_LOADED_OUT,
    output logic                               SC_LANE_SCHED_BUSY_OUT
);

    localparam int                PTR_W     = sc_ptr_width(NUM_LANES);
    localparam int                CNT_W     = $clog2(LOAD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [PTR_W-1:0]  PTR_RESET = PTR_W'(NUM_LANES - 1);

    sc_sched_state_t            state, state_next;
    logic [CNT_W-1:0]           counter, counter_next;
    logic [PTR_W-1:0]           pointer, pointer_next;
    logic [PTR_W-1:0]           grant_idx, grant_idx_next;
    logic [NUM_LANES-1:0]       grant_q, grant_next;
    logic [DATAWIDTH_BUS-1:0]   data_q, data_next;
    logic                       load_q, load_next;
    logic [NUM_LANES-1:0]       loaded_q, loaded_next;
    logic                       busy_q, busy_next;

    logic                       arb_valid;
    logic [PTR_W-1:0]           arb_idx;
    logic [NUM_LANES-1:0]       arb_onehot;
    logic [DATAWIDTH_BUS-1:0]   pattern_arr [NUM_LANES];
    logic                       granted_req;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_pattern
        assign pattern_arr[g] = SC_LANE_SCHED_PATTERN_IN[g*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    end

    assign granted_req = SC_LANE_SCHED_REQ_IN[grant_idx];

    sc_rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_arbiter (
        .req        (SC_LANE_SCHED_REQ_IN),
        .pointer    (pointer),
        .enable     (SC_LANE_SCHED_ENABLE_IN),
        .valid      (arb_valid),
        .sel_idx    (arb_idx),
        .sel_onehot (arb_onehot)
    );

    // Next-state and next-output decode; the granted lane dropping its request aborts the service.
    always_comb begin
        state_next     = state;
        counter_next   = counter;
        pointer_next   = pointer;
        grant_idx_next = grant_idx;
        grant_next     = grant_q;
        data_next      = data_q;
        load_next      = load_q;
        loaded_next    = '0;
        case (state)
            IDLE: begin
                load_next = 1'b0;
                if (arb_valid) begin
                    grant_next     = arb_onehot;
                    grant_idx_next = arb_idx;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                if (!granted_req) begin
                    state_next   = IDLE;
                    grant_next   = '0;
                    load_next    = 1'b0;
                    counter_next = '0;
                end else begin
                    data_next    = pattern_arr[grant_idx];
                    counter_next = '0;
                    load_next    = 1'b1;
                    state_next   = LOAD;
                end
            end
            LOAD: begin
                if (!granted_req) begin
                    state_next   = IDLE;
                    grant_next   = '0;
                    load_next    = 1'b0;
                    counter_next = '0;
                end else if (counter == CNT_LAST) begin
                    state_next   = ACK;
                    load_next    = 1'b0;
                    loaded_next  = grant_q;
                    pointer_next = grant_idx;
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
            ACK: begin
                state_next = IDLE;
                grant_next = '0;
                load_next  = 1'b0;
            end
            default: begin
                state_next     = IDLE;
                counter_next   = '0;
                pointer_next   = PTR_RESET;
                grant_idx_next = '0;
                grant_next     = '0;
                data_next      = '0;
                load_next      = 1'b0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State, counter, pointer and all output registers; reset returns everything to idle at once.
    always_ff @(posedge SC_STATEMACHINE_NVE_CLOCK_50 or posedge SC_STATEMACHINE_NVE_RESET) begin
        if (SC_STATEMACHINE_NVE_RESET) begin
            state     <= IDLE;
            counter   <= '0;
            pointer   <= PTR_RESET;
            grant_idx <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            load_q    <= 1'b0;
            loaded_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_next;
            counter   <= counter_next;
            pointer   <= pointer_next;
            grant_idx <= grant_idx_next;
            grant_q   <= grant_next;
            data_q    <= data_next;
            load_q    <= load_next;
            loaded_q  <= loaded_next;
            busy_q    <= busy_next;
        end
    end

    assign SC_LANE_SCHED_GRANT_OUT  = grant_q;
    assign SC_LANE_SCHED_DATA_OUT   = data_q;
    assign SC_LANE_SCHED_LOAD_OUT   = load_q;
    assign SC_LANE_SCHED_LOADED_OUT = loaded_q;
    assign SC_LANE_SCHED_BUSY_OUT   = busy_q;

endmodule

// File: tb/tb_sc_lane_load_scheduler.sv
// Self-checking bench for the lane load scheduler: scenario tasks with a
// scoreboard of expected (lane, pattern) services popped on each LOADED pulse.
module tb_sc_lane_load_scheduler;

    localparam int DW = 8;
    localparam int NL = 4;
    localparam int LC = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [NL-1:0]    req;
    logic [NL*DW-1:0] pattern;
    logic [NL-1:0]    grant;
    logic [DW-1:0]    data;
    logic             load;
    logic [NL-1:0]    loaded;
    logic             busy;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int          lane;
        logic [7:0]  data;
    } exp_t;
    exp_t sb[$];

    sc_lane_load_scheduler #(
        .DATAWIDTH_BUS (DW),
        .NUM_LANES     (NL),
        .LOAD_CYCLES   (LC)
    ) dut (
        .SC_STATEMACHINE_NVE_CLOCK_50 (clk),
        .SC_STATEMACHINE_NVE_RESET    (rst),
        .SC_LANE_SCHED_ENABLE_IN      (enable),
        .SC_LANE_SCHED_REQ_IN         (req),
        .SC_LANE_SCHED_PATTERN_IN     (pattern),
        .SC_LANE_SCHED_GRANT_OUT      (grant),
        .SC_LANE_SCHED_DATA_OUT       (data),
        .SC_LANE_SCHED_LOAD_OUT       (load),
        .SC_LANE_SCHED_LOADED_OUT     (loaded),
        .SC_LANE_SCHED_BUSY_OUT       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [NL-1:0] v);
        for (int i = 0; i < NL; i++)
            if (v[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        enable  = 1'b1;
        pattern = '0;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_loaded(input int max_cycles, output int lane, output logic [7:0] d,
                               output bit timeout);
        timeout = 1'b1;
        lane    = -1;
        d       = '0;
        for (int k = 0; k < max_cycles; k++) begin
            tick();
            if (loaded !== '0) begin
                lane    = onehot_idx(loaded);
                d       = data;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (grant !== '0)  begin fails++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
        checks++; if (data !== '0)   begin fails++; $display("[TB] FAIL reset_data got %h want 00", data); end
        checks++; if (load !== 1'b0) begin fails++; $display("[TB] FAIL reset_load got %b want 0", load); end
        checks++; if (loaded !== '0) begin fails++; $display("[TB] FAIL reset_loaded got %b want 0000", loaded); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        int   load_bad;
        exp_t e;
        do_reset();
        pattern[0 +: DW] = 8'hA5;
        req = 4'b0001;
        sb.push_back('{0, 8'hA5});
        tick(); // cycle 1
        checks++; if (grant !== 4'b0001) begin fails++; $display("[TB] FAIL single_grant_c1 got %b want 0001", grant); end
        checks++; if (load !== 1'b0)     begin fails++; $display("[TB] FAIL single_load_c1 got %b want 0", load); end
        checks++; if (busy !== 1'b1)     begin fails++; $display("[TB] FAIL single_busy_c1 got %b want 1", busy); end
        tick(); // cycle 2
        checks++; if (data !== 8'hA5) begin fails++; $display("[TB] FAIL single_data_c2 got %h want a5", data); end
        load_bad = 0;
        for (int k = 0; k < LC; k++) begin
            if (load !== 1'b1 || loaded !== '0) load_bad++;
            tick();
        end
        // now at cycle 10
        checks++; if (load_bad !== 0) begin fails++; $display("[TB] FAIL single_strobe_c2_c9 bad cycles got %0d want 0", load_bad); end
        checks++; if (loaded !== 4'b0001) begin fails++; $display("[TB] FAIL single_loaded_c10 got %b want 0001", loaded); end
        checks++; if (load !== 1'b0) begin fails++; $display("[TB] FAIL single_load_c10 got %b want 0", load); end
        e = sb.pop_front();
        checks++; if (data !== e.data) begin fails++; $display("[TB] FAIL single_sb_data got %h want %h", data, e.data); end
        req = '0;
        tick(); // cycle 11
        checks++; if (busy !== 1'b0)  begin fails++; $display("[TB] FAIL single_busy_c11 got %b want 0", busy); end
        checks++; if (grant !== '0)   begin fails++; $display("[TB] FAIL single_grant_c11 got %b want 0000", grant); end
        checks++; if (loaded !== '0)  begin fails++; $display("[TB] FAIL single_loaded_c11 got %b want 0000", loaded); end
        checks++; if (data !== 8'hA5) begin fails++; $display("[TB] FAIL single_data_held got %h want a5", data); end
    endtask

    task automatic test_round_robin();
        int         lane;
        logic [7:0] d;
        bit         to;
        exp_t       e;
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            for (int i = 0; i < NL; i++) pattern[i*DW +: DW] = 8'(8'h11 * (i + 1) + 8'h40);
            if (phase == 0) begin
                req = 4'b1111;
                for (int i = 0; i < NL; i++) sb.push_back('{i, 8'(8'h11 * (i + 1) + 8'h40)});
            end else begin
                req = 4'b1010;
                sb.push_back('{1, 8'h62});
                sb.push_back('{3, 8'h84});
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                wait_loaded(40, lane, d, to);
                checks++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL rr_timeout phase %0d got timeout want loaded lane %0d", phase, e.lane); end
                checks++; if (lane !== e.lane) begin fails++; $display("[TB] FAIL rr_order phase %0d got lane %0d want %0d", phase, lane, e.lane); end
                checks++; if (d !== e.data) begin fails++; $display("[TB] FAIL rr_data phase %0d got %h want %h", phase, d, e.data); end
                tick();
                if (lane >= 0) req[lane] = 1'b0;
            end
            req = '0;
        end
    endtask

    task automatic test_abort();
        int         lane;
        int         stray;
        logic [7:0] d;
        bit         to;
        exp_t       e;
        do_reset();
        pattern[2*DW +: DW] = 8'h5A;
        pattern[3*DW +: DW] = 8'hC3;
        req = 4'b0100;
        repeat (5) tick(); // cycle 5 = 4th LOAD cycle
        req = 4'b0000;
        tick(); // cycle 6
        checks++; if (load !== 1'b0) begin fails++; $display("[TB] FAIL abort_load got %b want 0", load); end
        checks++; if (grant !== '0)  begin fails++; $display("[TB] FAIL abort_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            if (loaded !== '0 || load !== 1'b0) stray++;
            tick();
        end
        checks++; if (stray !== 0) begin fails++; $display("[TB] FAIL abort_no_loaded stray cycles got %0d want 0", stray); end
        req = 4'b1100;
        sb.push_back('{2, 8'h5A});
        e = sb.pop_front();
        wait_loaded(30, lane, d, to);
        checks++; if (to !== 1'b0)     begin fails++; $display("[TB] FAIL abort_reserve_timeout got timeout want loaded"); end
        checks++; if (lane !== e.lane) begin fails++; $display("[TB] FAIL abort_pointer_kept got lane %0d want %0d", lane, e.lane); end
        checks++; if (d !== e.data)    begin fails++; $display("[TB] FAIL abort_reserve_data got %h want %h", d, e.data); end
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_capture();
        int   cap_bad;
        exp_t e;
        do_reset();
        pattern[1*DW +: DW] = 8'h3C;
        req = 4'b0010;
        sb.push_back('{1, 8'h3C});
        tick(); // cycle 1
        tick(); // cycle 2
        cap_bad = 0;
        for (int k = 0; k < LC; k++) begin
            if (data !== 8'h3C) cap_bad++;
            if (k == 2) pattern[1*DW +: DW] = 8'hFF;
            tick();
        end
        checks++; if (cap_bad !== 0) begin fails++; $display("[TB] FAIL capture_hold bad cycles got %0d want 0", cap_bad); end
        e = sb.pop_front();
        checks++; if (onehot_idx(loaded) !== e.lane) begin fails++; $display("[TB] FAIL capture_loaded got %b want lane %0d", loaded, e.lane); end
        checks++; if (data !== e.data) begin fails++; $display("[TB] FAIL capture_data_at_loaded got %h want %h", data, e.data); end
        req = '0;
        tick();
    endtask

    task automatic test_enable();
        int         idle_bad;
        int         lane;
        logic [7:0] d;
        bit         to;
        exp_t       e;
        do_reset();
        enable = 1'b0;
        pattern[2*DW +: DW] = 8'h77;
        req = 4'b0100;
        idle_bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (grant !== '0 || busy !== 1'b0) idle_bad++;
        end
        checks++; if (idle_bad !== 0) begin fails++; $display("[TB] FAIL enable_low_hold bad cycles got %0d want 0", idle_bad); end
        enable = 1'b1;
        sb.push_back('{2, 8'h77});
        tick();
        checks++; if (grant !== 4'b0100) begin fails++; $display("[TB] FAIL enable_grant got %b want 0100", grant); end
        tick();
        tick();
        tick();
        enable = 1'b0; // mid-LOAD
        e = sb.pop_front();
        wait_loaded(20, lane, d, to);
        checks++; if (to !== 1'b0)     begin fails++; $display("[TB] FAIL enable_drop_timeout got timeout want loaded"); end
        checks++; if (lane !== e.lane) begin fails++; $display("[TB] FAIL enable_drop_lane got %0d want %0d", lane, e.lane); end
        checks++; if (d !== e.data)    begin fails++; $display("[TB] FAIL enable_drop_data got %h want %h", d, e.data); end
        idle_bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (grant !== '0 || busy !== 1'b0) idle_bad++;
        end
        checks++; if (idle_bad !== 0) begin fails++; $display("[TB] FAIL enable_idle_holds bad cycles got %0d want 0", idle_bad); end
        req    = '0;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        int         nload;
        int         lane;
        logic [7:0] d;
        exp_t       e;
        do_reset();
        pattern[0 +: DW] = 8'hE7;
        req = 4'b0001;
        repeat (6) tick(); // cycle 6 = 5th LOAD cycle
        rst = 1'b1;
        #1;
        checks++; if ({grant, data, load, loaded, busy} !== '0) begin
            fails++;
            $display("[TB] FAIL midreset_outputs got grant=%b data=%h load=%b loaded=%b busy=%b want all 0",
                     grant, data, load, loaded, busy);
        end
        tick();
        rst = 1'b0;
        sb.push_back('{0, 8'hE7});
        tick();
        checks++; if (grant !== 4'b0001) begin fails++; $display("[TB] FAIL midreset_regrant got %b want 0001", grant); end
        nload = 0;
        lane  = -1;
        d     = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (load === 1'b1) nload++;
            if (loaded !== '0) begin
                lane = onehot_idx(loaded);
                d    = data;
                break;
            end
        end
        e = sb.pop_front();
        checks++; if (nload !== LC)    begin fails++; $display("[TB] FAIL midreset_strobes got %0d want %0d", nload, LC); end
        checks++; if (lane !== e.lane) begin fails++; $display("[TB] FAIL midreset_loaded_lane got %0d want %0d", lane, e.lane); end
        checks++; if (d !== e.data)    begin fails++; $display("[TB] FAIL midreset_data got %h want %h", d, e.data); end
        req = '0;
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        req     = '0;
        pattern = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_capture();
        test_enable();
        test_reset_mid();
        checks++; if (sb.size() !== 0) begin fails++; $display("[TB] FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
